id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Decode stage directly downstream of the 18-bit instruction memory in the pipelined processor.
//  - Accepts {op[1:0], a[7:0], b[7:0]} words from fetch.
//  - Splits each word into opcode, operand A and operand B, plus a one-hot ALU select.
//  - Flags divide-by-zero.
//  - Buffers up to DEPTH decoded words in order, so execute-stage backpressure never drops an instruction.
// PARAMETERS
//  DATA_W  8  operand width; instr width = OP_W + 2*DATA_W
//  OP_W    2  opcode width
//  DEPTH   2  skid-buffer entries (power of two, >= 2)
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high reset
//  instr_valid  in   1       instr is valid this cycle (fetch asserts it one cycle after issuing pc)
//  instr        in   18      {op, a, b}; op = instr[17:16], a = instr[15:8], b = instr[7:0]
//  id_ready     out  1       stage can accept instr this cycle
//  id_valid     out  1       decoded word is on the outputs
//  ex_ready     in   1       execute consumes the output word when id_valid && ex_ready
//  id_op        out  2       opcode of the head entry
//  id_a         out  8       operand A of the head entry
//  id_b         out  8       operand B of the head entry
//  id_alu_sel   out  4       one-hot select: bit n set when id_op == n
//  id_div0      out  1       id_op == OP_DIV && id_b == 0
//  id_retired   out  16      count of words consumed by execute
// BEHAVIOUR
//  - Reset: while reset is high, all entries are flushed, count = 0, and these outputs are 0:
//    id_valid, id_op, id_a, id_b, id_alu_sel, id_div0, id_retired, id_ready.
//    id_ready rises to 1 in the first cycle after reset deasserts.
//  - Push = instr_valid && id_ready. Pop = id_valid && ex_ready. Both are evaluated on the same edge.
//  - id_ready = !reset && (count < DEPTH). It depends only on registered state, never on ex_ready,
//    so there is no combinational path from ex_ready to id_ready.
//  - Latency: a word pushed at edge N into an empty buffer drives the outputs after edge N, with id_valid = 1.
//  - Ordering: strict FIFO; outputs always reflect the head entry.
//  - Decode is performed on push and stored per entry; the outputs are registered.
//  - Simultaneous push and pop:
//    - count unchanged;
//    - head advances;
//    - with count = 1, the new word becomes head on the next cycle (no bubble).
//  - Full (count == DEPTH): id_ready = 0; an instr_valid word offered in this cycle is not taken.
//    Fetch must hold pc/instr until it is accepted.
//  - Empty: id_valid = 0; id_op, id_a, id_b, id_alu_sel and id_div0 hold their last values.
//    ex_ready is ignored.
//  - Pointers: wrap modulo DEPTH.
//  - id_retired: +1 per pop; wraps from 16'hFFFF to 0.
//  - Reset mid-operation: all buffered words are discarded with no pop; id_retired is cleared.
//  - id_div0 is informational; the word is still delivered.
//  - Arithmetic: none on operands; fields pass through bit-exact.
// STRUCTURE
//  Shared package proc_pkg (also used by IM and EX):
//  - OP_W, DATA_W, INSTR_W
//  - OP_ADD = 0, OP_SUB = 1, OP_MUL = 2, OP_DIV = 3
//  - typedef instr_t (packed {op, a, b})
//  - typedef dec_t ({op, a, b, alu_sel, div0})
//  Sub-module id_skid_fifo:
//  - parameterised DEPTH-entry FIFO of dec_t;
//  - provides count, push/pop, head register.
//  id_stage holds the combinational decoder, the FIFO instance and the retire counter.
// TESTING
//  1. Reset for 3 cycles with instr_valid = 1 -> id_valid = 0 and id_ready = 0 throughout;
//     id_ready = 1 in the first cycle after reset.
//  2. ex_ready = 1; push {2'd0, 8'd100, 8'd50}
//     -> next cycle: id_valid = 1, id_op = 0, id_a = 100, id_b = 50, id_alu_sel = 4'b0001.
//  3. ex_ready = 0; push 3 back-to-back words
//     -> first 2 accepted, id_ready = 0 on the third; raise ex_ready
//     -> all 3 delivered in order, none lost or duplicated.
//  4. Push {2'd3, 8'd100, 8'd0} -> id_div0 = 1, id_alu_sel = 4'b1000;
//     push {2'd3, 8'd100, 8'd25} -> id_div0 = 0.
//  5. Buffer holding 2 words, assert reset for 1 cycle
//     -> id_valid = 0, id_retired = 0 next cycle; the stale words never appear.
//  6. Force id_retired = 16'hFFFE, perform 2 pops -> id_retired reads 16'hFFFF, then 16'h0000.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor types: instruction word layout, opcodes and the decoded-word record.
package proc_pkg;
  localparam int OP_W    = 2;
  localparam int DATA_W  = 8;
  localparam int INSTR_W = OP_W + 2*DATA_W;
  localparam int ALU_W   = 1 << OP_W;

  localparam logic [OP_W-1:0] OP_ADD = 2'd0;
  localparam logic [OP_W-1:0] OP_SUB = 2'd1;
  localparam logic [OP_W-1:0] OP_MUL = 2'd2;
  localparam logic [OP_W-1:0] OP_DIV = 2'd3;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } instr_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ALU_W-1:0]  alu_sel;
    logic              div0;
  } dec_t;

  function automatic dec_t decode(input instr_t i);
    dec_t d;
    d.op         = i.op;
    d.a          = i.a;
    d.b          = i.b;
    d.alu_sel    = '0;
    d.alu_sel[i.op] = 1'b1;
    d.div0       = (i.op == OP_DIV) && (i.b == '0);
    return d;
  endfunction
endpackage

// File: rtl/id_skid_fifo.sv
// In-order buffer of decoded words with a registered head entry.
module id_skid_fifo
  import proc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  dec_t          din,
  input  logic          pop,
  output dec_t          head,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  dec_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0] remain;
  dec_t          head_nxt;

  // Next head: oldest surviving stored entry, else the word arriving now, else hold.
  always_comb begin
    rd_nxt   = rd_ptr + PW'(pop);
    remain   = count - CW'(pop);
    head_nxt = head;
    if (remain != '0)
      head_nxt = mem[rd_nxt];
    else if (push)
      head_nxt = din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      head  <= head_nxt;
    end
  end
endmodule

// File: rtl/id_stage.sv
// Decode stage: splits fetch words, decodes on entry, buffers in order, counts retirements.
module id_stage
  import proc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [INSTR_W-1:0]  instr,
  output logic                id_ready,
  output logic                id_valid,
  input  logic                ex_ready,
  output logic [OP_W-1:0]     id_op,
  output logic [DATA_W-1:0]   id_a,
  output logic [DATA_W-1:0]   id_b,
  output logic [ALU_W-1:0]    id_alu_sel,
  output logic                id_div0,
  output logic [15:0]         id_retired
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          push, pop;
  logic [CW-1:0] count;
  dec_t          dec, head;

  // Ready comes only from registered occupancy, never from ex_ready.
  assign id_ready = !reset && (count < CW'(DEPTH));
  assign id_valid = (count != '0);
  assign push     = instr_valid && id_ready;
  assign pop      = id_valid && ex_ready;
  assign dec      = decode(instr_t'(instr));

  id_skid_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (dec),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  assign id_op      = head.op;
  assign id_a       = head.a;
  assign id_b       = head.b;
  assign id_alu_sel = head.alu_sel;
  assign id_div0    = head.div0;

  always_ff @(posedge clk) begin
    if (reset)
      id_retired <= '0;
    else if (pop)
      id_retired <= id_retired + 16'd1;
  end
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, decode, backpressure, div0, mid-run reset, retire wrap.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [17:0] instr;
  logic        id_ready, id_valid, ex_ready;
  logic [1:0]  id_op;
  logic [7:0]  id_a, id_b;
  logic [3:0]  id_alu_sel;
  logic        id_div0;
  logic [15:0] id_retired;

  int n_cmp = 0;
  int n_err = 0;

  id_stage #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .id_ready(id_ready), .id_valid(id_valid), .ex_ready(ex_ready),
    .id_op(id_op), .id_a(id_a), .id_b(id_b), .id_alu_sel(id_alu_sel),
    .id_div0(id_div0), .id_retired(id_retired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [3:0] sel, input logic d0);
    chk({tag, ".valid"}, 16'(id_valid), 16'd1);
    chk({tag, ".op"},    16'(id_op), 16'(op));
    chk({tag, ".a"},     16'(id_a), 16'(a));
    chk({tag, ".b"},     16'(id_b), 16'(b));
    chk({tag, ".sel"},   16'(id_alu_sel), 16'(sel));
    chk({tag, ".div0"},  16'(id_div0), 16'(d0));
  endtask

  initial begin
    // 1. reset with instr_valid high
    reset = 1'b1; instr_valid = 1'b1; instr = {2'd1, 8'hAA, 8'h55}; ex_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst.valid", 16'(id_valid), 16'd0);
      chk("rst.ready", 16'(id_ready), 16'd0);
    end
    chk("rst.retired", id_retired, 16'd0);
    chk("rst.op", 16'(id_op), 16'd0);
    chk("rst.a", 16'(id_a), 16'd0);
    chk("rst.sel", 16'(id_alu_sel), 16'd0);
    instr_valid = 1'b0; reset = 1'b0;
    #1;
    chk("post_rst.ready", 16'(id_ready), 16'd1);

    // 2. single push, delivered next cycle
    instr_valid = 1'b1; instr = {2'd0, 8'd100, 8'd50};
    step();
    chk_head("add", 2'd0, 8'd100, 8'd50, 4'b0001, 1'b0);
    instr_valid = 1'b0;
    step();
    chk("add.popped", 16'(id_valid), 16'd0);
    chk("add.retired", id_retired, 16'd1);
    chk("add.hold_a", 16'(id_a), 16'd100);

    // 3. backpressure: third word refused until space frees
    ex_ready = 1'b0;
    instr_valid = 1'b1; instr = {2'd1, 8'd1, 8'd2};
    step();
    instr = {2'd2, 8'd3, 8'd4};
    step();
    instr = {2'd3, 8'd5, 8'd6};
    chk("full.ready", 16'(id_ready), 16'd0);
    step();
    chk_head("bp.w1", 2'd1, 8'd1, 8'd2, 4'b0010, 1'b0);
    ex_ready = 1'b1;
    step();
    chk_head("bp.w2", 2'd2, 8'd3, 8'd4, 4'b0100, 1'b0);
    chk("bp.ready", 16'(id_ready), 16'd1);
    step();
    chk_head("bp.w3", 2'd3, 8'd5, 8'd6, 4'b1000, 1'b0);
    instr_valid = 1'b0;
    step();
    chk("bp.empty", 16'(id_valid), 16'd0);
    chk("bp.retired", id_retired, 16'd4);

    // 4. divide-by-zero flag
    instr_valid = 1'b1; instr = {2'd3, 8'd100, 8'd0};
    step();
    chk_head("div0", 2'd3, 8'd100, 8'd0, 4'b1000, 1'b1);
    instr = {2'd3, 8'd100, 8'd25};
    step();
    chk_head("div25", 2'd3, 8'd100, 8'd25, 4'b1000, 1'b0);
    instr_valid = 1'b0;
    step();
    chk("div.retired", id_retired, 16'd6);

    // 5. reset with two buffered words
    ex_ready = 1'b0; instr_valid = 1'b1;
    instr = {2'd0, 8'd7, 8'd7};
    step();
    instr = {2'd1, 8'd8, 8'd8};
    step();
    chk("midrst.full", 16'(id_ready), 16'd0);
    instr_valid = 1'b0; reset = 1'b1;
    step();
    chk("midrst.valid", 16'(id_valid), 16'd0);
    chk("midrst.retired", id_retired, 16'd0);
    reset = 1'b0; ex_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("midrst.stale", 16'(id_valid), 16'd0);
    end
    chk("midrst.retired2", id_retired, 16'd0);

    // 6. retire counter wrap: stream one word per cycle until 0xFFFE pops
    instr_valid = 1'b1; instr = {2'd2, 8'd9, 8'd9};
    for (int i = 0; i < 65535; i++) step();
    chk("wrap.fffe", id_retired, 16'hFFFE);
    instr_valid = 1'b0;
    step();
    chk("wrap.ffff", id_retired, 16'hFFFF);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    chk("wrap.0000", id_retired, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
